// File: rtl/fetch_stack_if.sv
// Bundles the fetch_stack control inputs and status outputs.
//   master: drives s_inc/s_stack/push/pop/jump_addr/clr_err, observes status.
//   slave : the fetch_stack side (samples controls, drives pc/sp/flags).
interface fetch_stack_if #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic            s_inc;
    logic            s_stack;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] jump_addr;
    logic            clr_err;
    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic            empty;
    logic            full;
    logic            ovf;
    logic            unf;

    modport master (
        output s_inc, s_stack, push, pop, jump_addr, clr_err,
        input  pc, sp, empty, full, ovf, unf
    );

    modport slave (
        input  s_inc, s_stack, push, pop, jump_addr, clr_err,
        output pc, sp, empty, full, ovf, unf
    );
endinterface

// File: rtl/fetch_stack.sv
// Program counter with a hardware return-address stack.
//   clk, reset : single clock, asynchronous active-high reset
//   bus.slave  : s_inc/s_stack/push/pop/jump_addr/clr_err in,
//                pc (registered), sp (occupancy), empty/full (from sp),
//                ovf/unf (sticky error flags, cleared by clr_err) out
module fetch_stack #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stack_if.slave bus
);
    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] stack_q [DEPTH];

    logic            empty;
    logic            full;
    logic [PC_W-1:0] pc_inc;
    logic [SP_W-1:0] sp_m1;
    logic [PC_W-1:0] stack_top;
    logic            do_push;
    logic            do_pop;
    logic            ovf_set;
    logic            unf_set;
    logic            take_ret;

    assign empty  = (sp_q == '0);
    assign full   = (sp_q == SP_W'(DEPTH));
    assign pc_inc = pc_q + PC_W'(1);
    assign sp_m1  = sp_q - SP_W'(1);
    // Only read when sp > 0, so sp-1 always lands on a live entry.
    assign stack_top = stack_q[sp_m1[IDX_W-1:0]];

    // push and pop together cancel out: nothing moves and no flag is raised.
    assign do_push  = bus.push & ~bus.pop & ~full;
    assign ovf_set  = bus.push & ~bus.pop &  full;
    assign do_pop   = bus.pop  & ~bus.push & ~empty;
    assign unf_set  = bus.pop  & ~bus.push &  empty;
    assign take_ret = bus.s_stack & do_pop;

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;

        if (take_ret)
            pc_d = stack_top;
        else if (bus.s_inc)
            pc_d = pc_inc;
        else
            pc_d = bus.jump_addr;

        if (do_push)
            sp_d = sp_q + SP_W'(1);
        else if (do_pop)
            sp_d = sp_m1;

        // Clear first, then set, so a fresh error in the clearing cycle sticks.
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage has no reset; entries at or above sp are never observable.
    always_ff @(posedge clk) begin
        if (do_push && !reset)
            stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
    end

    assign bus.pc    = pc_q;
    assign bus.sp    = sp_q;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_fetch_stack.sv
module tb_fetch_stack;
    localparam int PC_W  = 10;
    localparam int DEPTH = 8;

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic [3:0] sp;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q [$];
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    fetch_stack_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    fetch_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the DUT state against the oldest expectation.
    initial begin
        exp_t e;
        logic exp_empty, exp_full;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_empty = (e.sp == 4'd0);
                exp_full  = (e.sp == 4'd8);
                n_cmp++;
                if (bus.pc !== e.pc || bus.sp !== e.sp || bus.empty !== exp_empty ||
                    bus.full !== exp_full || bus.ovf !== e.ovf || bus.unf !== e.unf) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h sp=%0d empty=%b full=%b ovf=%b unf=%b, want pc=%h sp=%0d empty=%b full=%b ovf=%b unf=%b",
                             e.name, bus.pc, bus.sp, bus.empty, bus.full, bus.ovf, bus.unf,
                             e.pc, e.sp, exp_empty, exp_full, e.ovf, e.unf);
                end
            end
        end
    end

    task automatic expect_state(input string nm, input logic [9:0] epc, input logic [3:0] esp,
                                input logic eo, input logic eu);
        exp_t e;
        e.name = nm; e.pc = epc; e.sp = esp; e.ovf = eo; e.unf = eu;
        exp_q.push_back(e);
    endtask

    // Called right after a falling edge: drive, take one rising edge, queue expectation.
    task automatic step(input logic si, input logic ss, input logic pu, input logic po,
                        input logic [9:0] ja, input logic cl, input string nm,
                        input logic [9:0] epc, input logic [3:0] esp, input logic eo, input logic eu);
        bus.s_inc = si; bus.s_stack = ss; bus.push = pu; bus.pop = po;
        bus.jump_addr = ja; bus.clr_err = cl;
        @(posedge clk);
        #1;
        expect_state(nm, epc, esp, eo, eu);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.s_inc = 1'b0; bus.s_stack = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        bus.jump_addr = '0; bus.clr_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        expect_state("reset", 10'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        stim_done = 1'b0;
        idle_inputs();
        reset = 1'b1;
        #1;
        expect_state("reset_init", 10'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential increment; jump_addr set to prove s_inc wins over it.
        for (int i = 1; i <= 3; i++)
            step(1, 0, 0, 0, 10'h2AA, 0, "inc", 10'(i), 4'd0, 0, 0);

        // Call at pc=3, two increments, return to 4.
        step(0, 0, 1, 0, 10'h040, 0, "call40", 10'h040, 4'd1, 0, 0);
        step(1, 0, 0, 0, 10'h000, 0, "inc41",  10'h041, 4'd1, 0, 0);
        step(1, 0, 0, 0, 10'h000, 0, "inc42",  10'h042, 4'd1, 0, 0);
        step(0, 1, 0, 1, 10'h000, 0, "ret4",   10'h004, 4'd0, 0, 0);
        step(1, 0, 0, 0, 10'h000, 0, "inc5",   10'h005, 4'd0, 0, 0);
        step(1, 0, 0, 0, 10'h000, 0, "inc6",   10'h006, 4'd0, 0, 0);

        // Nine calls: the eighth fills the stack, the ninth overflows.
        for (int k = 0; k < 9; k++)
            step(0, 0, 1, 0, 10'h100 + 10'(k * 16), 0, "call_fill",
                 10'h100 + 10'(k * 16), (k < 8) ? 4'(k + 1) : 4'd8, (k == 8), 0);
        // Unwind in LIFO order; jump_addr nonzero to prove the return wins.
        for (int k = 7; k >= 0; k--)
            step(0, 1, 0, 1, 10'h3C3, 0, "ret_unwind",
                 (k == 0) ? 10'h007 : 10'h101 + 10'((k - 1) * 16), 4'(k), 1, 0);
        step(1, 0, 0, 0, 10'h000, 1, "clr_ovf", 10'h008, 4'd0, 0, 0);

        // Underflow from reset, clear, set-wins-over-clear.
        do_reset();
        step(1, 1, 0, 1, 10'h000, 0, "pop_empty", 10'h001, 4'd0, 0, 1);
        step(1, 0, 0, 0, 10'h000, 1, "clr_unf",   10'h002, 4'd0, 0, 0);
        step(1, 1, 0, 1, 10'h000, 1, "set_wins",  10'h003, 4'd0, 0, 1);
        step(1, 0, 0, 0, 10'h000, 1, "clr_unf2",  10'h004, 4'd0, 0, 0);

        // PC wrap, and a call from the top address pushes 0.
        step(0, 0, 0, 0, 10'h3FF, 0, "jmp3ff",    10'h3FF, 4'd0, 0, 0);
        step(1, 0, 0, 0, 10'h000, 0, "wrap",      10'h000, 4'd0, 0, 0);
        step(0, 0, 0, 0, 10'h3FF, 0, "jmp3ff_b",  10'h3FF, 4'd0, 0, 0);
        step(0, 0, 1, 0, 10'h030, 0, "call_wrap", 10'h030, 4'd1, 0, 0);
        step(0, 1, 0, 1, 10'h077, 0, "ret_wrap",  10'h000, 4'd0, 0, 0);

        // push+pop together at sp=2, discard pop, s_stack without pop.
        step(0, 0, 1, 0, 10'h010, 0, "call10",    10'h010, 4'd1, 0, 0);
        step(0, 0, 1, 0, 10'h020, 0, "call20",    10'h020, 4'd2, 0, 0);
        step(1, 1, 1, 1, 10'h0EE, 0, "push_pop",  10'h021, 4'd2, 0, 0);
        step(0, 0, 0, 1, 10'h050, 0, "discard",   10'h050, 4'd1, 0, 0);
        step(1, 1, 0, 0, 10'h0EE, 0, "sstk_only", 10'h051, 4'd1, 0, 0);
        step(0, 1, 0, 1, 10'h0EE, 0, "ret1",      10'h001, 4'd0, 0, 0);

        // Build sp=3 with ovf=1, then asynchronous reset between edges.
        for (int k = 0; k < 9; k++)
            step(0, 0, 1, 0, 10'h200 + 10'(k), 0, "call_fill2",
                 10'h200 + 10'(k), (k < 8) ? 4'(k + 1) : 4'd8, (k == 8), 0);
        for (int k = 0; k < 5; k++)
            step(1, 0, 0, 1, 10'h000, 0, "discard2", 10'h209 + 10'(k), 4'(7 - k), 1, 0);
        idle_inputs();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_state("async_reset", 10'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 0, 10'h000, 0, "post_reset", 10'h001, 4'd0, 0, 0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stack.md
FETCH_STACK -- requirements
Module: fetch_stack

Interface
REQ-001 Parameter PC_W, default 10, program-counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 8, number of return-stack entries (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 s_inc  input  1  1 = next PC is pc+1; 0 = next PC is jump_addr (unless a return is taken).
REQ-006 s_stack  input  1  1 = next PC is taken from the stack top (return), valid only with pop=1.
REQ-007 push  input  1  push pc+1 onto the return stack (call).
REQ-008 pop  input  1  pop the return stack.
REQ-009 jump_addr  input  PC_W  absolute jump/call target.
REQ-010 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-011 pc  output  PC_W  current program counter, registered; drives program-memory address.
REQ-012 sp  output  log2(DEPTH)+1  current stack occupancy, 0..DEPTH.
REQ-013 empty  output  1  sp == 0, combinational from sp.
REQ-014 full  output  1  sp == DEPTH, combinational from sp.
REQ-015 ovf  output  1  sticky: a push was attempted while full.
REQ-016 unf  output  1  sticky: a pop was attempted while empty.

Function
REQ-017 Next-PC priority each cycle: return (s_stack=1, pop=1, push=0, empty=0) -> stack top; else s_inc=1 -> pc+1; else jump_addr.
REQ-018 pc+1 wraps modulo 2^PC_W; pc = 2^PC_W-1 with s_inc=1 gives pc = 0 next cycle, no flag.
REQ-019 Push (push=1, pop=0, full=0): entry[sp] <= pc+1 (wrapped), sp <= sp+1; pc update per REQ-017 in the same edge.
REQ-020 Push while full: no write, sp unchanged, ovf <= 1; pc update still per REQ-017.
REQ-021 Pop (pop=1, push=0, empty=0): sp <= sp-1; stack top is entry[sp-1], read combinationally before the edge.
REQ-022 Pop while empty: sp unchanged, unf <= 1; a return is not taken and pc follows s_inc/jump_addr.
REQ-023 pop=1 with s_stack=0: sp decremented (discard), pc follows s_inc/jump_addr.
REQ-024 s_stack=1 with pop=0: s_stack ignored, pc follows s_inc/jump_addr, stack unchanged.
REQ-025 push=1 and pop=1 together: stack and sp unchanged, no flag set, no return taken, pc follows s_inc/jump_addr.
REQ-026 Latency: pc, sp, and the flags update on the edge following the inputs; full/empty follow sp with zero delay.
REQ-027 clr_err=1 clears ovf and unf on the edge; if a new error occurs in the same cycle, the flag is set (set wins).
REQ-028 Stack entries hold no reset value; entries at index >= sp are never visible at any output.
REQ-029 Inputs are sampled only on clk; no combinational path from any input to pc.

Reset
REQ-030 While reset=1, immediately and independent of clk: pc=0, sp=0, empty=1, full=0, ovf=0, unf=0.
REQ-031 Reset asserted during a push/pop cycle aborts it; the first edge after reset release behaves per Function from the reset state.

Verification
REQ-032 Reset, then 5 cycles with s_inc=1 -> pc 0,1,2,3,4,5; sp=0, empty=1.
REQ-033 At pc=3: call (push=1, s_inc=0, jump_addr=0x40) -> pc=0x40, sp=1; then after 2 increments, return (pop=1, s_stack=1) -> pc=4, sp=0, empty=1.
REQ-034 DEPTH=8: 9 consecutive calls -> sp=8, full=1 after the 8th; the 9th sets ovf=1, sp stays 8, pc=jump_addr; then 8 returns unwind the addresses in LIFO order.
REQ-035 From reset, return (pop=1, s_stack=1, s_inc=1) -> unf=1, sp=0, pc=1; clr_err=1 for one cycle -> unf=0.
REQ-036 pc=0x3FF, s_inc=1 -> pc=0x000; push=1 and pop=1 together at sp=2 -> sp stays 2, no flags, pc follows s_inc.
REQ-037 Assert reset asynchronously mid-cycle with sp=3 and ovf=1 -> pc=0, sp=0, ovf=0 before the next clk edge.
